upscale_fetch_ctrl: RTL and testbench

Sequencer for the 2x horizontal / 2x vertical linear upscaler in the VGA display path. It reads 320x240 12-bit source pixels from a synchronous frame buffer and presents a left/right pixel pair plus the odd-column flag to the interpolation datapath for every 640x480 output pixel. It primes a two-entry pixel window during horizontal blanking and then fetches one source pixel per two output pixels from a single read port.

---
 rtl/upscale_fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_upscale_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/upscale_fetch_ctrl.sv
// Fetch sequencer for the 2x/2x linear upscaler: primes a two-pixel window in
// horizontal blanking, then streams one source read per two output pixels.
module upscale_fetch_ctrl #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [9:0]        disp_y,
    input  logic              de,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] p1_data,
    output logic [DATA_W-1:0] p2_data,
    output logic              x_is_odd,
    output logic              pix_valid,
    output logic              err_underrun
);

    localparam int K_W = $clog2(SRC_W);
    localparam logic [8:0]  LAST_ROW = 9'(SRC_H - 1);
    localparam logic [31:0] ADDR_MAX = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << ADDR_W) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME0,
        PRIME1,
        PRIME2,
        READY,
        ACTIVE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_reg;
    logic [K_W-1:0]      k_reg;
    logic                phase_reg;
    logic                rd_issued_reg;
    logic [DATA_W-1:0]   s0_reg;
    logic [DATA_W-1:0]   s1_reg;

    logic [8:0]          half_row;
    logic [8:0]          row_clamped;
    logic [31:0]         base_wide;
    logic [ADDR_W-1:0]   base_sat;
    logic                fetch_ok;
    logic                active_cycle;
    logic                active_read;
    logic                prime_read;
    logic [31:0]         addr_wide;
    logic                unused_bits;

    assign unused_bits = disp_y[0];

    // Vertical doubling: output rows 2n and 2n+1 share source row n.
    assign half_row    = disp_y[9:1];
    assign row_clamped = (half_row > LAST_ROW) ? LAST_ROW : half_row;

    generate
        if (SRC_W == 320) begin : g_shift_mul
            assign base_wide = (32'(row_clamped) << 8) + (32'(row_clamped) << 6);
        end else begin : g_generic_mul
            assign base_wide = 32'(row_clamped) * 32'(SRC_W);
        end
    endgenerate

    assign base_sat = (base_wide > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0] : base_wide[ADDR_W-1:0];

    // Reads are strobed in the cycle they are needed so the data lands on the odd phase.
    assign fetch_ok     = (32'(k_reg) + 32'd2) <= 32'(SRC_W - 1);
    assign active_cycle = de && !line_start && ((state == READY) || (state == ACTIVE));
    assign active_read  = active_cycle && !phase_reg && fetch_ok;
    assign prime_read   = (state == PRIME0) || (state == PRIME1);
    assign rd_en        = prime_read || active_read;

    always_comb begin
        addr_wide = 32'(base_reg) + 32'(k_reg) + 32'd2;
        if (state == PRIME0) begin
            addr_wide = 32'(base_reg);
        end else if (state == PRIME1) begin
            addr_wide = 32'(base_reg) + 32'd1;
        end
    end

    assign rd_addr = !rd_en ? '0
                   : (addr_wide > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0]
                   : addr_wide[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            base_reg      <= '0;
            k_reg         <= '0;
            phase_reg     <= 1'b0;
            rd_issued_reg <= 1'b0;
            s0_reg        <= '0;
            s1_reg        <= '0;
            p1_data       <= '0;
            p2_data       <= '0;
            x_is_odd      <= 1'b0;
            pix_valid     <= 1'b0;
            err_underrun  <= 1'b0;
        end else begin
            rd_issued_reg <= active_read;
            if (line_start) begin
                base_reg  <= base_sat;
                k_reg     <= '0;
                phase_reg <= 1'b0;
                pix_valid <= 1'b0;
                state     <= PRIME0;
                if (de) begin
                    err_underrun <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        pix_valid <= 1'b0;
                        phase_reg <= 1'b0;
                        if (de) begin
                            err_underrun <= 1'b1;
                        end
                    end
                    PRIME0, PRIME1, PRIME2: begin
                        if (state == PRIME1) begin
                            s0_reg <= rd_data;
                        end
                        if (state == PRIME2) begin
                            s1_reg <= rd_data;
                        end
                        // Video started before the window was full: drop the line.
                        if (de) begin
                            err_underrun <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= (state == PRIME0) ? PRIME1
                                   : (state == PRIME1) ? PRIME2 : READY;
                        end
                    end
                    READY, ACTIVE: begin
                        if (de) begin
                            p1_data   <= s0_reg;
                            p2_data   <= s1_reg;
                            x_is_odd  <= phase_reg;
                            pix_valid <= 1'b1;
                            phase_reg <= ~phase_reg;
                            state     <= ACTIVE;
                            if (phase_reg) begin
                                s0_reg <= s1_reg;
                                // No read past the right edge: s1 holds, replicating the last pixel.
                                if (rd_issued_reg) begin
                                    s1_reg <= rd_data;
                                end
                                if (32'(k_reg) < 32'(SRC_W - 1)) begin
                                    k_reg <= k_reg + 1'b1;
                                end
                            end
                        end else begin
                            pix_valid <= 1'b0;
                            phase_reg <= 1'b0;
                            state     <= (state == ACTIVE) ? IDLE : READY;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upscale_fetch_ctrl.sv
// Scoreboard bench for upscale_fetch_ctrl: frame buffer holds src[a] = a[11:0],
// expected pixels and read addresses are queued by stimulus and popped by a monitor.
module tb_upscale_fetch_ctrl;

    localparam int SRC_W = 320;

    typedef struct packed {
        logic [11:0] p1;
        logic [11:0] p2;
        logic        odd;
    } pix_t;

    logic        clk;
    logic        reset_n;
    logic        line_start;
    logic [9:0]  disp_y;
    logic        de;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic [11:0] p1_data;
    logic [11:0] p2_data;
    logic        x_is_odd;
    logic        pix_valid;
    logic        err_underrun;

    pix_t        exp_pix[$];
    logic [16:0] exp_rd[$];
    int          n_checks;
    int          n_fail;
    int          rd_count;

    upscale_fetch_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .line_start   (line_start),
        .disp_y       (disp_y),
        .de           (de),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .p1_data      (p1_data),
        .p2_data      (p2_data),
        .x_is_odd     (x_is_odd),
        .pix_valid    (pix_valid),
        .err_underrun (err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame buffer with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= rd_addr[11:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel or a read.
    initial begin
        pix_t        e;
        logic [16:0] a;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pix_valid) begin
                    if (exp_pix.size() == 0) begin
                        chk("pix_unexpected", 32'(pix_valid), 32'd0);
                    end else begin
                        e = exp_pix.pop_front();
                        chk("p1_data", 32'(p1_data), 32'(e.p1));
                        chk("p2_data", 32'(p2_data), 32'(e.p2));
                        chk("x_is_odd", 32'(x_is_odd), 32'(e.odd));
                        $display("pix p1=%03h p2=%03h odd=%0b", p1_data, p2_data, x_is_odd);
                    end
                end
                if (rd_en) begin
                    rd_count++;
                    if (exp_rd.size() == 0) begin
                        chk("rd_unexpected", 32'(rd_en), 32'd0);
                    end else begin
                        a = exp_rd.pop_front();
                        chk("rd_addr", 32'(rd_addr), 32'(a));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_p1"}, 32'(p1_data), 32'd0);
        chk({tag, "_p2"}, 32'(p2_data), 32'd0);
        chk({tag, "_odd"}, 32'(x_is_odd), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    endtask

    // One display line: line_start, 3 priming cycles, then ncyc cycles of de.
    // rst_at >= 0 pulses reset_n low at that active column instead of finishing the line.
    task automatic run_line(input int y, input int ncyc, input int base, input int rst_at);
        int   k;
        int   k1;
        int   rd_start;
        int   rd_exp;
        bit   aborted;
        pix_t e;
        aborted = 1'b0;
        @(posedge clk); #1;
        rd_start   = rd_count;
        line_start = 1'b1;
        disp_y     = 10'(y);
        exp_rd.push_back(17'(base));
        exp_rd.push_back(17'(base + 1));
        rd_exp = 2;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("prime_reads", 32'(rd_count - rd_start), 32'd2);
        for (int n = 0; n < ncyc && !aborted; n++) begin
            if (n == rst_at) begin
                reset_n = 1'b0;
                #2;
                check_all_zero("async_rst");
                exp_pix.delete();
                exp_rd.delete();
                rd_start = rd_count;
                repeat (3) begin
                    @(posedge clk); #1;
                end
                reset_n = 1'b1;
                repeat (10) begin
                    @(posedge clk); #1;
                end
                chk("post_rst_reads", 32'(rd_count - rd_start), 32'd0);
                aborted = 1'b1;
            end else begin
                de = 1'b1;
                k  = ((n >> 1) > SRC_W - 1) ? SRC_W - 1 : (n >> 1);
                k1 = (k + 1 > SRC_W - 1) ? SRC_W - 1 : k + 1;
                e.p1  = 12'(base + k);
                e.p2  = 12'(base + k1);
                e.odd = n[0];
                exp_pix.push_back(e);
                if (n[0] == 1'b0 && (n >> 1) + 2 <= SRC_W - 1) begin
                    exp_rd.push_back(17'(base + (n >> 1) + 2));
                    rd_exp++;
                end
                @(posedge clk); #1;
            end
        end
        de = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        if (!aborted) begin
            chk("line_reads", 32'(rd_count - rd_start), 32'(rd_exp));
            chk("pix_drained", 32'(exp_pix.size()), 32'd0);
        end
        $display("line y=%0d cycles=%0d base=%0d reads=%0d", y, ncyc, base, rd_count - rd_start);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rd_count   = 0;
        reset_n    = 1'b0;
        line_start = 1'b0;
        disp_y     = '0;
        de         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        chk("reset_err", 32'(err_underrun), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Full line at row 0, then 10 extra cycles of right-edge repeat.
        run_line(0, 640, 0, -1);
        run_line(0, 650, 0, -1);
        // Truncated line followed by a fresh line at a new base.
        run_line(0, 100, 0, -1);
        run_line(5, 80, 640, -1);
        run_line(479, 40, 76480, -1);
        run_line(500, 40, 76480, -1);
        chk("err_clean", 32'(err_underrun), 32'd0);

        // Underrun: de rises during PRIME1, line must produce nothing.
        @(posedge clk); #1;
        line_start = 1'b1;
        disp_y     = 10'd0;
        exp_rd.push_back(17'd0);
        exp_rd.push_back(17'd1);
        @(posedge clk); #1;
        line_start = 1'b0;
        @(posedge clk); #1;
        de = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        de = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("underrun_set", 32'(err_underrun), 32'd1);
        chk("underrun_rd_q", 32'(exp_rd.size()), 32'd0);
        $display("underrun line err_underrun=%0b", err_underrun);

        run_line(6, 40, 960, -1);
        chk("underrun_sticky", 32'(err_underrun), 32'd1);

        run_line(0, 400, 0, 200);

        chk("final_pix_q", 32'(exp_pix.size()), 32'd0);
        chk("final_rd_q", 32'(exp_rd.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
